// File: rtl/writeback_pcupdate_if.sv
// Commit, register-read and status signals between the SEQ datapath and the
// write-back / PC-update stage.
interface writeback_pcupdate_if;
  logic        wb_valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        instr_valid;
  logic        imem_error;
  logic        dmem_error;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] rvalA;
  logic [63:0] rvalB;
  logic [63:0] PC;
  logic [2:0]  stat;
  logic        halted;
  logic [63:0] retired;

  modport master (
    output wb_valid, icode, ifun, rA, rB, cnd, valE, valM, valC, valP,
    output instr_valid, imem_error, dmem_error, srcA, srcB,
    input  rvalA, rvalB, PC, stat, halted, retired
  );

  modport slave (
    input  wb_valid, icode, ifun, rA, rB, cnd, valE, valM, valC, valP,
    input  instr_valid, imem_error, dmem_error, srcA, srcB,
    output rvalA, rvalB, PC, stat, halted, retired
  );
endinterface

// File: rtl/writeback_pcupdate.sv
// Y86-64 SEQ write-back and PC update: register file write side, next-PC register,
// sticky processor status and retired-instruction counter.
module writeback_pcupdate #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned NREG     = 15
) (
  input logic                  Clk,
  input logic                  Rst_n,
  writeback_pcupdate_if.slave  wb
);

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] RSP     = 4'h4;
  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  typedef enum logic {StRun, StStop} state_e;

  state_e      state_q, state_d;
  logic [63:0] regs_q [NREG];
  logic [63:0] pc_q;
  logic [63:0] retired_q;
  logic [2:0]  stat_q;

  logic [3:0]  dst_e, dst_m;
  logic [63:0] new_pc;
  logic [2:0]  commit_stat;
  logic        commit, commit_ok;

  // ifun only matters upstream; cnd already carries its effect.
  logic unused_ifun;
  assign unused_ifun = ^wb.ifun;

  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    new_pc = wb.valP;
    commit_stat = StatAok;

    case (wb.icode)
      4'h2:                      dst_e = wb.cnd ? wb.rB : RNONE;
      4'h3, 4'h6:                dst_e = wb.rB;
      4'h8, 4'h9, 4'hA, 4'hB:    dst_e = RSP;
      default:                   dst_e = RNONE;
    endcase

    if (wb.icode == 4'h5 || wb.icode == 4'hB) dst_m = wb.rA;

    if (wb.icode == 4'h8 || (wb.icode == 4'h7 && wb.cnd)) new_pc = wb.valC;
    else if (wb.icode == 4'h9)                            new_pc = wb.valM;

    if (wb.imem_error || wb.dmem_error) commit_stat = StatAdr;
    else if (!wb.instr_valid)           commit_stat = StatIns;
    else if (wb.icode == 4'h0)          commit_stat = StatHlt;
  end

  assign commit    = (state_q == StRun) && wb.wb_valid;
  assign commit_ok = commit && (commit_stat == StatAok);

  always_comb begin
    state_d = state_q;
    if (commit && !commit_ok) state_d = StStop;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= StRun;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      stat_q    <= StatAok;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (commit && !commit_ok) stat_q <= commit_stat;
      if (commit_ok) begin
        pc_q      <= new_pc;
        retired_q <= retired_q + 64'd1;
        // valM has priority so popq %rsp leaves the popped value in %rsp.
        for (int unsigned i = 0; i < NREG; i++) begin
          if (dst_m == 4'(i))      regs_q[i] <= wb.valM;
          else if (dst_e == 4'(i)) regs_q[i] <= wb.valE;
        end
      end
    end
  end

  assign wb.rvalA   = (wb.srcA < 4'(NREG)) ? regs_q[wb.srcA] : '0;
  assign wb.rvalB   = (wb.srcB < 4'(NREG)) ? regs_q[wb.srcB] : '0;
  assign wb.PC      = pc_q;
  assign wb.stat    = stat_q;
  assign wb.halted  = (stat_q != StatAok);
  assign wb.retired = retired_q;

endmodule

// File: tb/tb_writeback_pcupdate.sv
// Directed bench for writeback_pcupdate: commits hand-built Y86-64 instructions and
// checks registers, PC, status and retired count against hand-computed values.
module tb_writeback_pcupdate;

  logic Clk;
  logic Rst_n;
  int   checks;
  int   errors;

  writeback_pcupdate_if wb ();

  writeback_pcupdate #(
    .RESET_PC (64'h0),
    .NREG     (15)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .wb    (wb)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [3:0] idx, input logic [63:0] exp);
    wb.srcA = idx;
    #1;
    chk(tag, wb.rvalA, exp);
  endtask

  task automatic idle();
    wb.wb_valid    = 1'b0;
    wb.icode       = 4'h1;
    wb.ifun        = 4'h0;
    wb.rA          = 4'hF;
    wb.rB          = 4'hF;
    wb.cnd         = 1'b0;
    wb.valE        = '0;
    wb.valM        = '0;
    wb.valC        = '0;
    wb.valP        = '0;
    wb.instr_valid = 1'b1;
    wb.imem_error  = 1'b0;
    wb.dmem_error  = 1'b0;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                       input logic cnd, input logic [63:0] vale, input logic [63:0] valm,
                       input logic [63:0] valc, input logic [63:0] valp);
    wb.wb_valid = 1'b1;
    wb.icode    = icode;
    wb.rA       = ra;
    wb.rB       = rb;
    wb.cnd      = cnd;
    wb.valE     = vale;
    wb.valM     = valm;
    wb.valC     = valc;
    wb.valP     = valp;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    #3;
    Rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    wb.srcA = 4'h3;
    wb.srcB = 4'hF;
    Rst_n   = 1'b0;
    #12;
    chk("reset_pc", wb.PC, 64'h0);
    chk("reset_stat", 64'(wb.stat), 64'd1);
    chk("reset_halted", 64'(wb.halted), 64'd0);
    chk("reset_retired", wb.retired, 64'd0);
    chk("reset_reg3", wb.rvalA, 64'd0);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // irmovq $10,%rbx; no bypass before the edge
    drive(4'h3, 4'hF, 4'h3, 1'b0, 64'd10, 64'd0, 64'd10, 64'd10);
    rd("irmov_nobypass", 4'h3, 64'd0);
    step();
    rd("irmov_reg3", 4'h3, 64'd10);
    chk("irmov_pc", wb.PC, 64'd10);
    chk("irmov_retired", wb.retired, 64'd1);

    // irmovq $0x100,%rsp then popq %rsp: valM wins over valE
    drive(4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'd0, 64'h100, 64'd20);
    step();
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h55, 64'd0, 64'd22);
    step();
    rd("popq_rsp", 4'h4, 64'h55);
    chk("popq_pc", wb.PC, 64'd22);
    chk("popq_retired", wb.retired, 64'd3);

    // jXX taken / not taken
    drive(4'h7, 4'hF, 4'hF, 1'b1, 64'd0, 64'd0, 64'h40, 64'd31);
    step();
    chk("jxx_taken_pc", wb.PC, 64'h40);
    drive(4'h7, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 64'h40, 64'h29);
    step();
    chk("jxx_fall_pc", wb.PC, 64'h29);

    // cmovXX not taken then taken
    drive(4'h2, 4'h3, 4'h5, 1'b0, 64'd10, 64'd0, 64'd0, 64'h2B);
    step();
    rd("cmov_nt_reg5", 4'h5, 64'd0);
    drive(4'h2, 4'h3, 4'h5, 1'b1, 64'h77, 64'd0, 64'd0, 64'h2D);
    step();
    rd("cmov_t_reg5", 4'h5, 64'h77);
    chk("cmov_pc", wb.PC, 64'h2D);

    // call, ret
    drive(4'h8, 4'hF, 4'hF, 1'b0, 64'hF8, 64'd0, 64'h80, 64'h60);
    step();
    chk("call_pc", wb.PC, 64'h80);
    rd("call_rsp", 4'h4, 64'hF8);
    drive(4'h9, 4'hF, 4'hF, 1'b0, 64'h100, 64'h1234, 64'd0, 64'h81);
    step();
    chk("ret_pc", wb.PC, 64'h1234);
    rd("ret_rsp", 4'h4, 64'h100);

    // mrmovq into %rsi, then an idle cycle with junk on the bus
    drive(4'h5, 4'h6, 4'h3, 1'b0, 64'h20, 64'hABC, 64'd0, 64'h1300);
    step();
    rd("mrmov_reg6", 4'h6, 64'hABC);
    wb.icode = 4'h3; wb.rB = 4'h7; wb.valE = 64'd99; wb.valP = 64'h9999;
    step();
    chk("idle_pc", wb.PC, 64'h1300);
    chk("idle_retired", wb.retired, 64'd10);
    rd("idle_reg7", 4'h7, 64'd0);
    wb.srcB = 4'hF;
    #1;
    chk("rnone_read", wb.rvalB, 64'd0);
    wb.srcB = 4'h5;
    #1;
    chk("portb_reg5", wb.rvalB, 64'h77);

    // halt is sticky
    drive(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 64'd0, 64'h1301);
    step();
    chk("halt_stat", 64'(wb.stat), 64'd2);
    chk("halt_halted", 64'(wb.halted), 64'd1);
    chk("halt_pc", wb.PC, 64'h1300);
    drive(4'h3, 4'hF, 4'h7, 1'b0, 64'd99, 64'd0, 64'd0, 64'h2000);
    step();
    rd("stop_reg7", 4'h7, 64'd0);
    chk("stop_pc", wb.PC, 64'h1300);
    chk("stop_retired", wb.retired, 64'd10);
    chk("stop_stat", 64'(wb.stat), 64'd2);

    // asynchronous reset without a clock edge
    #1;
    Rst_n = 1'b0;
    #1;
    chk("async_pc", wb.PC, 64'h0);
    chk("async_stat", 64'(wb.stat), 64'd1);
    chk("async_halted", 64'(wb.halted), 64'd0);
    chk("async_retired", wb.retired, 64'd0);
    rd("async_reg6", 4'h6, 64'd0);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // seed %rsi, then mrmovq with dmem fault
    drive(4'h3, 4'hF, 4'h6, 1'b0, 64'h33, 64'd0, 64'd0, 64'd10);
    step();
    drive(4'h5, 4'h6, 4'h3, 1'b0, 64'h20, 64'hDEAD, 64'd0, 64'd20);
    wb.dmem_error = 1'b1;
    step();
    chk("adr_stat", 64'(wb.stat), 64'd3);
    rd("adr_reg6", 4'h6, 64'h33);
    chk("adr_pc", wb.PC, 64'd10);
    chk("adr_retired", wb.retired, 64'd1);

    // invalid instruction
    do_reset();
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'd5, 64'd0, 64'd0, 64'd10);
    wb.instr_valid = 1'b0;
    step();
    chk("ins_stat", 64'(wb.stat), 64'd4);
    rd("ins_reg2", 4'h2, 64'd0);
    chk("ins_pc", wb.PC, 64'd0);

    // address fault outranks invalid instruction
    do_reset();
    drive(4'hC, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 64'd0, 64'd10);
    wb.instr_valid = 1'b0;
    wb.imem_error  = 1'b1;
    step();
    chk("prio_stat", 64'(wb.stat), 64'd3);
    chk("prio_halted", 64'(wb.halted), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
